// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared types and widths for the asynchronous SRAM bank controller.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_BE_W : pin widths of one 1M x 32 bank
//   sram_state_e                          : controller FSM states
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_e;

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if
//   Word request channel between the CPU memory stage and sram_ctrl.
//   req   : request valid (level), fields stable until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   be_n  : byte enables, active low (writes only)
//   wdata : write data
//   rdata : read data, valid in the ack cycle and held until the next read ack
//   ack   : one-cycle completion pulse
//   busy  : controller is not idle
//   modport master : requester side (CPU)
//   modport slave  : controller side (sram_ctrl)
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                   req;
  logic                   we;
  logic [SRAM_ADDR_W-1:0] addr;
  logic [SRAM_BE_W-1:0]   be_n;
  logic [SRAM_DATA_W-1:0] wdata;
  logic [SRAM_DATA_W-1:0] rdata;
  logic                   ack;
  logic                   busy;

  modport master (
    output req, we, addr, be_n, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, be_n, wdata,
    output rdata, ack, busy
  );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Bus-master controller for one 1M x 32 asynchronous SRAM bank. Converts a
//   single-outstanding req/ack word request into timed SRAM read and write
//   cycles. Every SRAM strobe comes straight from a flop, so the pins never
//   glitch. The tristate pad merge lives in the board top level.
// Parameters
//   READ_WAIT  : cycles oe_n/ce_n are held low before read data is sampled (>= 1)
//   WRITE_WAIT : cycles we_n is held low per write (>= 1)
// Ports
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   bus         : request channel (slave side)
//   ram_addr    : SRAM address pins
//   ram_be_n    : SRAM byte enables, active low
//   ram_ce_n    : chip enable, active low
//   ram_oe_n    : output enable, active low
//   ram_we_n    : write enable, active low
//   ram_data_o  : write data towards the pads
//   ram_data_oe : 1 = controller drives the data pads
//   ram_data_i  : data read back from the pads
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_if.slave             bus,
  output logic [SRAM_ADDR_W-1:0] ram_addr,
  output logic [SRAM_BE_W-1:0]   ram_be_n,
  output logic                   ram_ce_n,
  output logic                   ram_oe_n,
  output logic                   ram_we_n,
  output logic [SRAM_DATA_W-1:0] ram_data_o,
  output logic                   ram_data_oe,
  input  logic [SRAM_DATA_W-1:0] ram_data_i
);

  // A zero wait would leave no time for the SRAM access itself, so refuse
  // to build such a configuration.
  if (READ_WAIT < 1) begin : g_bad_read_wait
    $error("sram_ctrl: READ_WAIT must be at least 1");
  end
  if (WRITE_WAIT < 1) begin : g_bad_write_wait
    $error("sram_ctrl: WRITE_WAIT must be at least 1");
  end

  // One shared down-counter serves both the read and the write-pulse waits,
  // so it is sized for the longer of the two.
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  sram_state_e      state;
  logic [CNT_W-1:0] cnt;

  assign bus.busy = (state != ST_IDLE);

  // Single FSM. Address, byte enables and write data are latched into the
  // pin registers on the accepting edge and held for the whole transaction,
  // which keeps requester-side changes while busy away from the pins.
  // Writes run as setup / pulse / hold so address and data are stable on
  // both sides of the we_n low phase; the data drivers are only enabled on
  // the write path, so they never overlap with oe_n low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ram_addr    <= '0;
      ram_be_n    <= '1;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_data_o  <= '0;
      ram_data_oe <= 1'b0;
      bus.rdata   <= '0;
      bus.ack     <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            ram_addr   <= bus.addr;
            ram_data_o <= bus.wdata;
            ram_ce_n   <= 1'b0;
            if (bus.we) begin
              ram_be_n    <= bus.be_n;
              ram_data_oe <= 1'b1;
              ram_we_n    <= 1'b1;
              state       <= ST_WR_SETUP;
            end else begin
              // Reads always fetch the full word; the CPU picks bytes.
              ram_be_n <= '0;
              ram_oe_n <= 1'b0;
              cnt      <= RD_LOAD;
              state    <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.rdata <= ram_data_i;
            bus.ack   <= 1'b1;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_WR_SETUP: begin
          ram_we_n <= 1'b0;
          cnt      <= WR_LOAD;
          state    <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ram_we_n <= 1'b1;
            state    <= ST_WR_HOLD;
          end
        end

        ST_WR_HOLD: begin
          ram_ce_n    <= 1'b1;
          ram_data_oe <= 1'b0;
          bus.ack     <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          ram_ce_n    <= 1'b1;
          ram_oe_n    <= 1'b1;
          ram_we_n    <= 1'b1;
          ram_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Directed bench for sram_ctrl. Instance 0 uses the default waits (2/2),
//   instance 1 uses READ_WAIT=1 / WRITE_WAIT=1. Each instance talks to its
//   own behavioural SRAM that stores on the rising edge of we_n and drives
//   read data while ce_n and oe_n are both low.
//   Latency below is the number of clock edges from the edge that accepts
//   the request to the edge that raises ack.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();

  logic [19:0] ram_addr0, ram_addr1;
  logic [3:0]  ram_be_n0, ram_be_n1;
  logic        ram_ce_n0, ram_ce_n1;
  logic        ram_oe_n0, ram_oe_n1;
  logic        ram_we_n0, ram_we_n1;
  logic [31:0] ram_data_o0, ram_data_o1;
  logic        ram_data_oe0, ram_data_oe1;
  logic [31:0] ram_data_i0, ram_data_i1;

  sram_ctrl #(.READ_WAIT(2), .WRITE_WAIT(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .ram_addr(ram_addr0), .ram_be_n(ram_be_n0), .ram_ce_n(ram_ce_n0),
    .ram_oe_n(ram_oe_n0), .ram_we_n(ram_we_n0), .ram_data_o(ram_data_o0),
    .ram_data_oe(ram_data_oe0), .ram_data_i(ram_data_i0)
  );

  sram_ctrl #(.READ_WAIT(1), .WRITE_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .ram_addr(ram_addr1), .ram_be_n(ram_be_n1), .ram_ce_n(ram_ce_n1),
    .ram_oe_n(ram_oe_n1), .ram_we_n(ram_we_n1), .ram_data_o(ram_data_o1),
    .ram_data_oe(ram_data_oe1), .ram_data_i(ram_data_i1)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural SRAM halves
  logic [31:0] mem0 [bit [19:0]];
  logic [31:0] mem1 [bit [19:0]];
  logic [31:0] w0, w1;

  always @(posedge ram_we_n0) begin
    if (ram_ce_n0 === 1'b0 && ram_data_oe0 === 1'b1) begin
      w0 = mem0.exists(ram_addr0) ? mem0[ram_addr0] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (!ram_be_n0[b]) w0[8*b +: 8] = ram_data_o0[8*b +: 8];
      mem0[ram_addr0] = w0;
    end
  end

  always @(posedge ram_we_n1) begin
    if (ram_ce_n1 === 1'b0 && ram_data_oe1 === 1'b1) begin
      w1 = mem1.exists(ram_addr1) ? mem1[ram_addr1] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (!ram_be_n1[b]) w1[8*b +: 8] = ram_data_o1[8*b +: 8];
      mem1[ram_addr1] = w1;
    end
  end

  always_comb begin
    ram_data_i0 = 32'h0;
    if (ram_ce_n0 === 1'b0 && ram_oe_n0 === 1'b0 && mem0.exists(ram_addr0))
      ram_data_i0 = mem0[ram_addr0];
  end

  always_comb begin
    ram_data_i1 = 32'h0;
    if (ram_ce_n1 === 1'b0 && ram_oe_n1 === 1'b0 && mem1.exists(ram_addr1))
      ram_data_i1 = mem1[ram_addr1];
  end

  // Strobe-width monitors: count clock cycles each strobe spends active.
  int oe_low0, we_low0, doe_high0;
  int oe_low1, we_low1, doe_high1;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (ram_oe_n0 === 1'b0) oe_low0++;
    if (ram_we_n0 === 1'b0) we_low0++;
    if (ram_data_oe0 === 1'b1) doe_high0++;
    if (ram_oe_n1 === 1'b0) oe_low1++;
    if (ram_we_n1 === 1'b0) we_low1++;
    if (ram_data_oe1 === 1'b1) doe_high1++;
  end

  always @(negedge clk) begin
    if (ram_data_oe0 === 1'b1 && ram_oe_n0 === 1'b0) overlap_cnt++;
    if (ram_data_oe1 === 1'b1 && ram_oe_n1 === 1'b0) overlap_cnt++;
  end

  function automatic logic get_ack(input bit sel);
    return sel ? bus1.ack : bus0.ack;
  endfunction

  task automatic drive_fields(input bit sel, input logic req, input logic we,
                              input logic [19:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    if (sel) begin
      bus1.req = req; bus1.we = we; bus1.addr = a; bus1.be_n = be; bus1.wdata = d;
    end else begin
      bus0.req = req; bus0.we = we; bus0.addr = a; bus0.be_n = be; bus0.wdata = d;
    end
  endtask

  task automatic clear_monitors();
    oe_low0 = 0; we_low0 = 0; doe_high0 = 0;
    oe_low1 = 0; we_low1 = 0; doe_high1 = 0;
  endtask

  // Issues one request from idle, returns latency, pin snapshot just after
  // the accepting edge, and rdata in the ack cycle.
  task automatic run_txn(input bit sel, input logic we, input logic [19:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         output int lat, output logic [19:0] acc_addr,
                         output logic [3:0] acc_be, output logic [31:0] rd,
                         output bit timeout);
    @(negedge clk);
    clear_monitors();
    drive_fields(sel, 1'b1, we, a, be, d);
    @(posedge clk); #1;
    acc_addr = sel ? ram_addr1 : ram_addr0;
    acc_be   = sel ? ram_be_n1 : ram_be_n0;
    lat      = 0;
    timeout  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (get_ack(sel) === 1'b1) begin
        lat     = i;
        timeout = 1'b0;
        break;
      end
    end
    rd = sel ? bus1.rdata : bus0.rdata;
    drive_fields(sel, 1'b0, 1'b0, a, be, d);
  endtask

  task automatic test_reset();
    drive_fields(1'b0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0);
    drive_fields(1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus0.rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=%h", bus0.rdata, 32'h0); end
    checks++;
    if (ram_addr0 !== 20'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=%h", ram_addr0, 20'h0); end
    checks++;
    if (ram_be_n0 !== 4'hF) begin failures++; $display("[TB] FAIL reset_be_n got=%h exp=%h", ram_be_n0, 4'hF); end
    checks++;
    if ({ram_ce_n0, ram_oe_n0, ram_we_n0} !== 3'b111) begin
      failures++; $display("[TB] FAIL reset_strobes got=%b exp=%b", {ram_ce_n0, ram_oe_n0, ram_we_n0}, 3'b111);
    end
    checks++;
    if ({ram_data_oe0, bus0.ack, bus0.busy} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_oe_ack_busy got=%b exp=%b", {ram_data_oe0, bus0.ack, bus0.busy}, 3'b000);
    end
    checks++;
    if (ram_data_o0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_o got=%h exp=%h", ram_data_o0, 32'h0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_full();
    int lat; logic [19:0] aa; logic [3:0] ab; logic [31:0] rd; bit to; logic [31:0] m;
    run_txn(1'b0, 1'b1, 20'h00010, 4'h0, 32'hDEADBEEF, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 4) begin failures++; $display("[TB] FAIL write_latency got=%0d timeout=%0d exp=4", lat, to); end
    checks++;
    if (we_low0 != 2) begin failures++; $display("[TB] FAIL write_we_low got=%0d exp=2", we_low0); end
    checks++;
    if (doe_high0 != 4) begin failures++; $display("[TB] FAIL write_data_oe_high got=%0d exp=4", doe_high0); end
    checks++;
    if (aa !== 20'h00010 || ab !== 4'h0) begin
      failures++; $display("[TB] FAIL write_pins got=%h/%h exp=%h/%h", aa, ab, 20'h00010, 4'h0);
    end
    checks++;
    if (ram_data_oe0 !== 1'b0 || ram_ce_n0 !== 1'b1 || bus0.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL write_release got=%b%b%b exp=011", ram_data_oe0, ram_ce_n0, bus0.busy);
    end
    m = mem0.exists(20'h00010) ? mem0[20'h00010] : 32'h0;
    checks++;
    if (m !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL write_mem got=%h exp=%h", m, 32'hDEADBEEF); end
  endtask

  task automatic test_read();
    int lat; logic [19:0] aa; logic [3:0] ab; logic [31:0] rd; bit to;
    run_txn(1'b0, 1'b0, 20'h00010, 4'hF, 32'h0, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 2) begin failures++; $display("[TB] FAIL read_latency got=%0d timeout=%0d exp=2", lat, to); end
    checks++;
    if (oe_low0 != 2) begin failures++; $display("[TB] FAIL read_oe_low got=%0d exp=2", oe_low0); end
    checks++;
    if (ab !== 4'h0 || aa !== 20'h00010) begin
      failures++; $display("[TB] FAIL read_pins got=%h/%h exp=%h/%h", aa, ab, 20'h00010, 4'h0);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL read_data got=%h exp=%h", rd, 32'hDEADBEEF); end
    checks++;
    if (doe_high0 != 0) begin failures++; $display("[TB] FAIL read_no_drive got=%0d exp=0", doe_high0); end
  endtask

  task automatic test_byte_write();
    int lat; logic [19:0] aa; logic [3:0] ab; logic [31:0] rd; bit to;
    run_txn(1'b0, 1'b1, 20'h00010, 4'b1110, 32'h000000AA, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 4) begin failures++; $display("[TB] FAIL bytewr_latency got=%0d timeout=%0d exp=4", lat, to); end
    checks++;
    if (ab !== 4'b1110) begin failures++; $display("[TB] FAIL bytewr_be got=%b exp=%b", ab, 4'b1110); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL bytewr_rdata_kept got=%h exp=%h", rd, 32'hDEADBEEF); end
    run_txn(1'b0, 1'b0, 20'h00010, 4'hF, 32'h0, lat, aa, ab, rd, to);
    checks++;
    if (to || rd !== 32'hDEADBEAA) begin failures++; $display("[TB] FAIL bytewr_readback got=%h exp=%h", rd, 32'hDEADBEAA); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; logic [31:0] m;
    @(negedge clk);
    clear_monitors();
    drive_fields(1'b0, 1'b1, 1'b1, 20'hFFFFF, 4'h0, 32'h12345678);
    @(posedge clk); #1;
    lat = 0; to = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus0.req = ~bus0.req;
      @(posedge clk); #1;
      if (bus0.ack === 1'b1) begin lat = i; to = 1'b0; break; end
    end
    bus0.req = 1'b1;
    bus0.we  = 1'b0;
    checks++;
    if (to || lat != 4) begin failures++; $display("[TB] FAIL b2b_write_latency got=%0d timeout=%0d exp=4", lat, to); end
    checks++;
    if (bus0.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ack_idle got=%b exp=0", bus0.busy); end
    @(posedge clk); #1;
    checks++;
    if (bus0.busy !== 1'b1 || ram_oe_n0 !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_one_idle busy=%b oe_n=%b exp busy=1 oe_n=0", bus0.busy, ram_oe_n0);
    end
    lat = 0; to = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus0.ack === 1'b1) begin lat = i; to = 1'b0; break; end
    end
    bus0.req = 1'b0;
    checks++;
    if (to || lat != 2) begin failures++; $display("[TB] FAIL b2b_read_latency got=%0d timeout=%0d exp=2", lat, to); end
    checks++;
    if (bus0.rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL b2b_rdata got=%h exp=%h", bus0.rdata, 32'h12345678); end
    m = mem0.exists(20'hFFFFF) ? mem0[20'hFFFFF] : 32'h0;
    checks++;
    if (m !== 32'h12345678) begin failures++; $display("[TB] FAIL b2b_mem got=%h exp=%h", m, 32'h12345678); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [19:0] aa; logic [3:0] ab; logic [31:0] rd; bit to; int seen;
    @(negedge clk);
    drive_fields(1'b0, 1'b1, 1'b1, 20'h00020, 4'h0, 32'h55555555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ram_we_n0 !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_pulse got=%b exp=0", ram_we_n0); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_ce_n0, ram_we_n0, ram_data_oe0, bus0.busy, bus0.ack} !== 5'b11000) begin
      failures++; $display("[TB] FAIL abort_release got=%b exp=%b",
                           {ram_ce_n0, ram_we_n0, ram_data_oe0, bus0.busy, bus0.ack}, 5'b11000);
    end
    bus0.req = 1'b0;
    seen = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus0.ack === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("[TB] FAIL abort_no_ack got=%0d exp=0", seen); end
    run_txn(1'b0, 1'b0, 20'h00010, 4'hF, 32'h0, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 2 || rd !== 32'hDEADBEAA) begin
      failures++; $display("[TB] FAIL abort_next_read lat=%0d data=%h exp lat=2 data=%h", lat, rd, 32'hDEADBEAA);
    end
  endtask

  task automatic test_param_sweep();
    int lat; logic [19:0] aa; logic [3:0] ab; logic [31:0] rd; bit to;
    run_txn(1'b1, 1'b1, 20'h00003, 4'h0, 32'hCAFEF00D, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 3) begin failures++; $display("[TB] FAIL sweep_write_latency got=%0d timeout=%0d exp=3", lat, to); end
    checks++;
    if (we_low1 != 1) begin failures++; $display("[TB] FAIL sweep_we_low got=%0d exp=1", we_low1); end
    run_txn(1'b1, 1'b0, 20'h00003, 4'hF, 32'h0, lat, aa, ab, rd, to);
    checks++;
    if (to || lat != 1) begin failures++; $display("[TB] FAIL sweep_read_latency got=%0d timeout=%0d exp=1", lat, to); end
    checks++;
    if (oe_low1 != 1) begin failures++; $display("[TB] FAIL sweep_oe_low got=%0d exp=1", oe_low1); end
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL sweep_rdata got=%h exp=%h", rd, 32'hCAFEF00D); end
  endtask

  initial begin
    rst = 1'b1;
    clear_monitors();
    test_reset();
    test_write_full();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_reset_abort();
    test_param_sweep();
    checks++;
    if (overlap_cnt != 0) begin failures++; $display("[TB] FAIL drive_overlap got=%0d exp=0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
